lsu_master: RTL
===============

// Module: lsu_master
// PURPOSE
//   Initiator side of the byte-addressed data memory interface. Accepts one load/store request at a
//   time from the CPU datapath. Checks alignment, range and opcode, then drives MemWrite/MemAdd/
//   MemWriData/Load/Store into the data memory and returns the load result or an error.
//   Sits between the execute stage and the data memory in the multicycle CPU.
// PARAMETERS
//   ADDR_W  10  data memory byte-address width; MemAdd = req_addr[ADDR_W-1:0]
//   CNT_W   16  width of each statistics counter
// PORTS
//   clk           in   1       clock; all state changes on posedge
//   rstn          in   1       asynchronous active-low reset
//   req_valid     in   1       request present
//   req_ready     out  1       request accepted on posedge when req_valid & req_ready
//   req_store     in   1       1 = store, 0 = load
//   req_op        in   3       load: 0 lw,1 lb,2 lbu,3 lh,4 lhu; store: 0 sw,1 sb,2 sh
//   req_addr      in   32      byte address
//   req_wdata     in   32      store data (low bytes used for sb/sh)
//   flush         in   1       cancel the in-flight operation
//   resp_valid    out  1       one-cycle response pulse
//   resp_rdata    out  32      load data (0 for stores/errors)
//   resp_err      out  1       1 = request rejected, memory untouched
//   resp_badaddr  out  32      offending address when resp_err, else 0
//   MemWrite      out  1       data memory write enable
//   MemAdd        out  ADDR_W  data memory byte address
//   MemWriData    out  32      data memory write data
//   Load          out  3       data memory load code (= req_op for loads)
//   Store         out  2       data memory store code (= req_op[1:0] for stores)
//   MemRedData    in   32      data memory read data, valid from the negedge of the ACCESS cycle
//   cnt_load, cnt_store, cnt_err  out  CNT_W  completed loads / stores / errors, wrap at 2**CNT_W
// BEHAVIOUR
//   States: IDLE, ACCESS, RESP. Reset (async) -> IDLE.
//   Reset values: all outputs 0 except req_ready=1. MemWrite drops immediately on rstn low.
//   req_ready = (state==IDLE) & ~flush.
//   On accept, register addr/wdata/op/store and evaluate error:
//     bad op: load op>4 or store op==3; misaligned: lw/sw addr[1:0]!=0, lh/lhu/sh addr[0]!=0;
//     out of range: addr[31:ADDR_W]!=0.
//   IDLE --accept, no error--> ACCESS; IDLE --accept, error--> RESP with err set.
//   ACCESS (exactly 1 cycle): MemAdd/Load/Store/MemWriData driven from registers.
//     MemWrite = store & ~flush; the write commits at the posedge ending ACCESS.
//     Load: capture MemRedData into resp_rdata at that posedge. ACCESS -> RESP.
//   RESP: resp_valid=1 for one cycle; resp_rdata, resp_err, resp_badaddr held for that cycle. RESP -> IDLE.
//   Latency: accept at edge T; good op resp_valid during cycle T+2, error resp_valid during cycle T+1.
//   Throughput: one op per 3 cycles (2 for errors). No request is accepted in ACCESS or RESP.
//   Outside ACCESS: MemWrite=0, Load=0, Store=0, MemAdd/MemWriData hold their last values.
//   Flush: in IDLE, blocks accept. In ACCESS, suppresses MemWrite and goes to IDLE with no response.
//     In RESP, drops resp_valid that cycle and goes to IDLE. Flushed ops do not count.
//   Counters: +1 on each delivered resp_valid (err -> cnt_err only). Wrap modulo 2**CNT_W.
//   Reset mid-operation: pending store is not written; no response is produced.
// TESTING
//   sw 0x11223344 @0x10, then lw @0x10 -> lw resp_valid at T+2, rdata=0x11223344; cnt_store=1, cnt_load=1.
//   sb 0x..80 @0x21, then lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080.
//   lw @0x12 / sh @0x13 / lw @0x400 / load op 6 -> resp_err=1 at T+1, badaddr=addr, MemWrite never high.
//   sw @0x30 with flush asserted in ACCESS -> MemWrite stays 0, no resp_valid, later lw @0x30 returns old data.
//   rstn low during ACCESS of a store -> MemWrite falls asynchronously, state IDLE, req_ready=1, counters 0.
//   Back-to-back req_valid held high -> accepts every 3rd edge, req_ready low in ACCESS and RESP.

Source files
------------

// File: rtl/lsu_master_if.sv
//==============================================================================
// Module  : lsu_master_if
// Brief   : Request/response, data-memory and statistics bundle for lsu_master.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface lsu_master_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              flush;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [31:0]       resp_badaddr;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAdd;
    logic [31:0]       MemWriData;
    logic [2:0]        Load;
    logic [1:0]        Store;
    logic [31:0]       MemRedData;
    logic [CNT_W-1:0]  cnt_load;
    logic [CNT_W-1:0]  cnt_store;
    logic [CNT_W-1:0]  cnt_err;

    modport master (
        input  req_valid, req_store, req_op, req_addr, req_wdata, flush, MemRedData,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr,
               MemWrite, MemAdd, MemWriData, Load, Store,
               cnt_load, cnt_store, cnt_err
    );

    modport slave (
        output req_valid, req_store, req_op, req_addr, req_wdata, flush, MemRedData,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr,
               MemWrite, MemAdd, MemWriData, Load, Store,
               cnt_load, cnt_store, cnt_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu_master.sv
//==============================================================================
// Module  : lsu_master
// Brief   : Single-outstanding load/store initiator for the byte-addressed data
//           memory; validates requests and returns load data or an error.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module lsu_master #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input wire          clk,
    input wire          rstn,
    lsu_master_if.master bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [31:0]       r_addr;
    logic [2:0]        r_op;
    logic              r_store;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_memadd;
    logic [31:0]       r_memwdata;
    logic [CNT_W-1:0]  r_cnt_load;
    logic [CNT_W-1:0]  r_cnt_store;
    logic [CNT_W-1:0]  r_cnt_err;

    logic w_ready;
    logic w_accept;
    logic w_bad_op;
    logic w_misalign;
    logic w_range;
    logic w_err;

    assign w_ready  = (r_state == c_IDLE) & ~bus.flush;
    assign w_accept = bus.req_valid & w_ready;

    // Request validation; stores decode their width from req_op[1:0]
    always_comb begin
        w_bad_op   = 1'b0;
        w_misalign = 1'b0;
        if (bus.req_store) begin
            w_bad_op = (bus.req_op == 3'd3);
            case (bus.req_op[1:0])
                2'd0:    w_misalign = |bus.req_addr[1:0];
                2'd2:    w_misalign = bus.req_addr[0];
                default: w_misalign = 1'b0;
            endcase
        end else begin
            w_bad_op = (bus.req_op > 3'd4);
            case (bus.req_op)
                3'd0:       w_misalign = |bus.req_addr[1:0];
                3'd3, 3'd4: w_misalign = bus.req_addr[0];
                default:    w_misalign = 1'b0;
            endcase
        end
    end

    assign w_range = |bus.req_addr[31:ADDR_W];
    assign w_err   = w_bad_op | w_misalign | w_range;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_next = w_err ? c_RESP : c_ACCESS;
            c_ACCESS: w_next = bus.flush ? c_IDLE : c_RESP;
            c_RESP:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Memory-side address/data only move on a good accept so they hold between accesses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_op       <= '0;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_memadd   <= '0;
            r_memwdata <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_op    <= bus.req_op;
            r_store <= bus.req_store;
            r_err   <= w_err;
            r_rdata <= '0;
            if (!w_err) begin
                r_memadd   <= bus.req_addr[ADDR_W-1:0];
                r_memwdata <= bus.req_wdata;
            end
        end else if ((r_state == c_ACCESS) && !bus.flush && !r_store) begin
            r_rdata <= bus.MemRedData;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_load  <= '0;
            r_cnt_store <= '0;
            r_cnt_err   <= '0;
        end else if ((r_state == c_RESP) && !bus.flush) begin
            if (r_err) begin
                r_cnt_err <= r_cnt_err + 1'b1;
            end else if (r_store) begin
                r_cnt_store <= r_cnt_store + 1'b1;
            end else begin
                r_cnt_load <= r_cnt_load + 1'b1;
            end
        end
    end

    always_comb begin
        bus.MemWrite     = 1'b0;
        bus.Load         = 3'd0;
        bus.Store        = 2'd0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.resp_err     = 1'b0;
        bus.resp_badaddr = '0;
        case (r_state)
            c_ACCESS: begin
                bus.MemWrite = r_store & ~bus.flush;
                bus.Load     = r_store ? 3'd0 : r_op;
                bus.Store    = r_store ? r_op[1:0] : 2'd0;
            end
            c_RESP: begin
                bus.resp_valid   = ~bus.flush;
                bus.resp_rdata   = r_rdata;
                bus.resp_err     = r_err;
                bus.resp_badaddr = r_err ? r_addr : 32'd0;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = w_ready;
    assign bus.MemAdd     = r_memadd;
    assign bus.MemWriData = r_memwdata;
    assign bus.cnt_load   = r_cnt_load;
    assign bus.cnt_store  = r_cnt_store;
    assign bus.cnt_err    = r_cnt_err;

endmodule

`default_nettype wire
